fft_job_sequencer: RTL and testbench

//  Sequences multi-frame FFT jobs between the AXI-Lite register decode and the DMA/compute path.
//  Per frame: issues one read DMA (source samples) and one write DMA (bit-reversed results), then waits for both dones.

---
 rtl/fft_job_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_fft_job_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_job_sequencer.sv
// Multi-frame FFT job sequencer: per frame issues a read and a write DMA, waits for both
// dones, steps the addresses by the strides, and reports completion/errors via sticky status and an irq.
module fft_job_sequencer #(
   parameter int AXI_ADDR_WIDTH  = 32,
   parameter int TOP_LEN_WIDTH   = 32,
   parameter int FRAME_CNT_WIDTH = 16,
   parameter int TIMEOUT_WIDTH   = 24
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       cfg_start,
   input  logic                       cfg_abort,
   input  logic [3:0]                 cfg_log2_point,
   input  logic [FRAME_CNT_WIDTH-1:0] cfg_num_frames,
   input  logic [AXI_ADDR_WIDTH-1:0]  cfg_src_addr,
   input  logic [AXI_ADDR_WIDTH-1:0]  cfg_dst_addr,
   input  logic [AXI_ADDR_WIDTH-1:0]  cfg_src_stride,
   input  logic [AXI_ADDR_WIDTH-1:0]  cfg_dst_stride,
   input  logic [TIMEOUT_WIDTH-1:0]   cfg_timeout,
   input  logic                       cfg_irq_en,
   input  logic                       irq_clear,
   output logic                       read_start,
   output logic                       read_restart,
   output logic                       top_read_valid,
   output logic [AXI_ADDR_WIDTH-1:0]  top_read_addr,
   output logic [TOP_LEN_WIDTH-1:0]   top_read_len,
   output logic                       write_start,
   output logic                       write_restart,
   output logic                       top_write_valid,
   output logic [AXI_ADDR_WIDTH-1:0]  top_write_addr,
   output logic [TOP_LEN_WIDTH-1:0]   top_write_len,
   input  logic                       read_done,
   input  logic                       write_done,
   output logic                       busy,
   output logic [FRAME_CNT_WIDTH-1:0] frames_done,
   output logic                       status_done,
   output logic [1:0]                 status_err,
   output logic                       interrupt_out
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, FINISH} state_t;

   localparam logic [1:0] ERR_CFG     = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_ABORT   = 2'd3;

   state_t                     state;
   logic [AXI_ADDR_WIDTH-1:0]  src_ptr, dst_ptr, src_stride, dst_stride;
   logic [FRAME_CNT_WIDTH-1:0] num_frames;
   logic [TIMEOUT_WIDTH-1:0]   timeout, wd_cnt;
   logic [TOP_LEN_WIDTH-1:0]   job_len;
   logic                       irq_en, rd_flag, wr_flag;

   logic                       cfg_ok, rd_seen, wr_seen, in_job;
   logic [TOP_LEN_WIDTH-1:0]   cfg_len;
   logic [AXI_ADDR_WIDTH-1:0]  src_nxt, dst_nxt;
   logic [FRAME_CNT_WIDTH-1:0] frames_nxt;
   logic [TIMEOUT_WIDTH-1:0]   wd_nxt;

   assign cfg_ok     = (cfg_log2_point >= 4'd3) && (cfg_log2_point <= 4'd12);
   assign cfg_len    = TOP_LEN_WIDTH'(8) << cfg_log2_point;
   assign rd_seen    = rd_flag | read_done;
   assign wr_seen    = wr_flag | write_done;
   assign src_nxt    = src_ptr + src_stride;
   assign dst_nxt    = dst_ptr + dst_stride;
   assign frames_nxt = frames_done + 1'b1;
   assign wd_nxt     = wd_cnt + 1'b1;
   assign in_job     = (state == ISSUE) || (state == WAIT) || (state == NEXT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= IDLE;
         src_ptr         <= '0;
         dst_ptr         <= '0;
         src_stride      <= '0;
         dst_stride      <= '0;
         num_frames      <= '0;
         timeout         <= '0;
         wd_cnt          <= '0;
         job_len         <= '0;
         irq_en          <= 1'b0;
         rd_flag         <= 1'b0;
         wr_flag         <= 1'b0;
         read_start      <= 1'b0;
         read_restart    <= 1'b0;
         top_read_valid  <= 1'b0;
         top_read_addr   <= '0;
         top_read_len    <= '0;
         write_start     <= 1'b0;
         write_restart   <= 1'b0;
         top_write_valid <= 1'b0;
         top_write_addr  <= '0;
         top_write_len   <= '0;
         busy            <= 1'b0;
         frames_done     <= '0;
         status_done     <= 1'b0;
         status_err      <= '0;
         interrupt_out   <= 1'b0;
      end else begin
         read_start      <= 1'b0;
         write_start     <= 1'b0;
         top_read_valid  <= 1'b0;
         top_write_valid <= 1'b0;
         read_restart    <= 1'b0;
         write_restart   <= 1'b0;
         // clear comes first so any set later in this block wins
         if (irq_clear) begin
            interrupt_out <= 1'b0;
            status_done   <= 1'b0;
            status_err    <= '0;
         end
         if (cfg_abort && in_job) begin
            state         <= FINISH;
            status_err    <= ERR_ABORT;
            busy          <= 1'b0;
            read_restart  <= 1'b1;
            write_restart <= 1'b1;
         end else begin
            case (state)
               IDLE: if (cfg_start) begin
                  status_done <= 1'b0;
                  status_err  <= '0;
                  frames_done <= '0;
                  irq_en      <= cfg_irq_en;
                  if (!cfg_ok) begin
                     status_err <= ERR_CFG;
                     state      <= FINISH;
                  end else if (cfg_num_frames == '0) begin
                     status_done <= 1'b1;
                     state       <= FINISH;
                  end else begin
                     src_ptr         <= cfg_src_addr;
                     dst_ptr         <= cfg_dst_addr;
                     src_stride      <= cfg_src_stride;
                     dst_stride      <= cfg_dst_stride;
                     num_frames      <= cfg_num_frames;
                     timeout         <= cfg_timeout;
                     job_len         <= cfg_len;
                     top_read_addr   <= cfg_src_addr;
                     top_write_addr  <= cfg_dst_addr;
                     top_read_len    <= cfg_len;
                     top_write_len   <= cfg_len;
                     read_start      <= 1'b1;
                     write_start     <= 1'b1;
                     top_read_valid  <= 1'b1;
                     top_write_valid <= 1'b1;
                     busy            <= 1'b1;
                     state           <= ISSUE;
                  end
               end
               ISSUE: begin
                  rd_flag <= 1'b0;
                  wr_flag <= 1'b0;
                  wd_cnt  <= '0;
                  state   <= WAIT;
               end
               WAIT: begin
                  rd_flag <= rd_seen;
                  wr_flag <= wr_seen;
                  wd_cnt  <= wd_nxt;
                  if (rd_seen && wr_seen) begin
                     state <= NEXT;
                  end else if ((timeout != '0) && (wd_nxt == timeout)) begin
                     status_err    <= ERR_TIMEOUT;
                     read_restart  <= 1'b1;
                     write_restart <= 1'b1;
                     busy          <= 1'b0;
                     state         <= FINISH;
                  end
               end
               NEXT: begin
                  frames_done <= frames_nxt;
                  src_ptr     <= src_nxt;
                  dst_ptr     <= dst_nxt;
                  if (frames_nxt == num_frames) begin
                     status_done <= 1'b1;
                     busy        <= 1'b0;
                     state       <= FINISH;
                  end else begin
                     top_read_addr   <= src_nxt;
                     top_write_addr  <= dst_nxt;
                     top_read_len    <= job_len;
                     top_write_len   <= job_len;
                     read_start      <= 1'b1;
                     write_start     <= 1'b1;
                     top_read_valid  <= 1'b1;
                     top_write_valid <= 1'b1;
                     state           <= ISSUE;
                  end
               end
               FINISH: begin
                  if (irq_en) interrupt_out <= 1'b1;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fft_job_sequencer.sv
// Scoreboard bench: expected DMA issues and job completions are queued by the stimulus,
// and monitors pop and compare whenever the DUT issues a frame or raises its interrupt.
module tb_fft_job_sequencer;

   typedef struct {
      logic [31:0] rd_addr;
      logic [31:0] wr_addr;
      logic [31:0] len;
   } issue_t;

   typedef struct {
      logic        done;
      logic [1:0]  err;
      logic [15:0] frames;
   } fin_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_start = 1'b0, cfg_abort = 1'b0, cfg_irq_en = 1'b1, irq_clear = 1'b0;
   logic [3:0]  cfg_log2_point = 4'd10;
   logic [15:0] cfg_num_frames = 16'd1;
   logic [31:0] cfg_src_addr = '0, cfg_dst_addr = '0, cfg_src_stride = '0, cfg_dst_stride = '0;
   logic [23:0] cfg_timeout = '0;
   logic        read_done = 1'b0, write_done = 1'b0;
   logic        read_start, read_restart, top_read_valid, write_start, write_restart, top_write_valid;
   logic [31:0] top_read_addr, top_read_len, top_write_addr, top_write_len;
   logic        busy, status_done, interrupt_out;
   logic [15:0] frames_done;
   logic [1:0]  status_err;

   fft_job_sequencer dut (
      .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
      .cfg_log2_point(cfg_log2_point), .cfg_num_frames(cfg_num_frames),
      .cfg_src_addr(cfg_src_addr), .cfg_dst_addr(cfg_dst_addr),
      .cfg_src_stride(cfg_src_stride), .cfg_dst_stride(cfg_dst_stride),
      .cfg_timeout(cfg_timeout), .cfg_irq_en(cfg_irq_en), .irq_clear(irq_clear),
      .read_start(read_start), .read_restart(read_restart), .top_read_valid(top_read_valid),
      .top_read_addr(top_read_addr), .top_read_len(top_read_len),
      .write_start(write_start), .write_restart(write_restart), .top_write_valid(top_write_valid),
      .top_write_addr(top_write_addr), .top_write_len(top_write_len),
      .read_done(read_done), .write_done(write_done), .busy(busy), .frames_done(frames_done),
      .status_done(status_done), .status_err(status_err), .interrupt_out(interrupt_out)
   );

   always #5 clk = ~clk;

   int     checks = 0, passes = 0;
   int     rs_cnt = 0, rr_cnt = 0, wr_cnt = 0;
   logic   irq_q = 1'b0;
   issue_t issue_q[$];
   fin_t   fin_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // issue monitor
   always @(negedge clk) begin
      if (rst_n && read_start) begin
         issue_t e;
         rs_cnt++;
         if (issue_q.size() == 0) chk("unexpected_issue", 1, 0);
         else begin
            e = issue_q.pop_front();
            chk("rd_addr", top_read_addr, e.rd_addr);
            chk("wr_addr", top_write_addr, e.wr_addr);
            chk("rd_len", top_read_len, e.len);
            chk("wr_len", top_write_len, e.len);
            chk("issue_strobes", {write_start, top_read_valid, top_write_valid}, 3'b111);
         end
      end
   end

   // completion monitor and restart counters
   always @(negedge clk) begin
      if (rst_n) begin
         if (read_restart) rr_cnt++;
         if (write_restart) wr_cnt++;
         if (interrupt_out && !irq_q) begin
            fin_t f;
            if (fin_q.size() == 0) chk("unexpected_irq", 1, 0);
            else begin
               f = fin_q.pop_front();
               chk("fin_done", status_done, f.done);
               chk("fin_err", status_err, f.err);
               chk("fin_frames", frames_done, f.frames);
               chk("fin_busy", busy, 0);
            end
         end
      end
      irq_q = rst_n ? interrupt_out : 1'b0;
   end

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic start(input logic [3:0] l2, input logic [15:0] nf, input logic [31:0] s,
                        input logic [31:0] d, input logic [31:0] ss, input logic [31:0] ds,
                        input logic [23:0] to);
      cfg_log2_point = l2; cfg_num_frames = nf; cfg_src_addr = s; cfg_dst_addr = d;
      cfg_src_stride = ss; cfg_dst_stride = ds; cfg_timeout = to;
      cfg_start = 1'b1;
      cyc();
      cfg_start = 1'b0;
   endtask

   task automatic wait_issue(output int n);
      n = 0;
      while (1) begin
         @(negedge clk);
         if (read_start) return;
         n++;
         if (n > 100) begin chk("issue_timeout", 0, 1); return; end
      end
   endtask

   task automatic wait_irq();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (interrupt_out) return;
      end
      chk("irq_timeout", 0, 1);
   endtask

   task automatic clear_irq();
      irq_clear = 1'b1;
      cyc();
      irq_clear = 1'b0;
      @(negedge clk);
      chk("irq_cleared", {interrupt_out, status_done, status_err}, 0);
   endtask

   // rd_d / wr_d: WAIT cycle on which each done pulses (0 = never)
   task automatic pulse_dones(input int rd_d, input int wr_d);
      int m = (rd_d > wr_d) ? rd_d : wr_d;
      for (int i = 1; i <= m; i++) begin
         cyc();
         read_done = (i == rd_d);
         write_done = (i == wr_d);
      end
      cyc();
      read_done = 1'b0; write_done = 1'b0;
   endtask

   initial begin
      int n, rs0;
      repeat (3) cyc();
      @(negedge clk);
      chk("rst_ctl", {busy, read_start, write_start, read_restart, interrupt_out, status_done, status_err}, 0);
      chk("rst_data", {frames_done, top_read_addr, top_read_len}, 0);
      rst_n = 1'b1;
      cyc();

      // T1: single 1024-point frame
      issue_q.push_back('{32'h1000, 32'h8000, 32'd8192});
      fin_q.push_back('{1'b1, 2'd0, 16'd1});
      start(4'd10, 16'd1, 32'h1000, 32'h8000, 0, 0, 0);
      wait_issue(n);
      chk("start_latency", n, 0);
      pulse_dones(50, 50);
      wait_irq();
      clear_irq();

      // T2: three frames with strides, plus a start while busy that must be ignored
      rs0 = rs_cnt;
      issue_q.push_back('{32'h1000, 32'h8000, 32'd8192});
      issue_q.push_back('{32'h3000, 32'hC000, 32'd8192});
      issue_q.push_back('{32'h5000, 32'h10000, 32'd8192});
      fin_q.push_back('{1'b1, 2'd0, 16'd3});
      start(4'd10, 16'd3, 32'h1000, 32'h8000, 32'h2000, 32'h4000, 0);
      wait_issue(n);
      pulse_dones(2, 3);
      wait_issue(n);
      chk("min_frame_gap", n, 1);
      start(4'd3, 16'd1, 32'hDEAD0000, 32'hBEEF0000, 0, 0, 0);
      pulse_dones(1, 1);
      wait_issue(n);
      pulse_dones(4, 2);
      wait_irq();
      chk("t2_issue_count", rs_cnt - rs0, 3);
      clear_irq();

      // T3: write before read, then both together; source address wraps
      issue_q.push_back('{32'hFFFFFFC0, 32'h100, 32'd64});
      issue_q.push_back('{32'h0, 32'h140, 32'd64});
      fin_q.push_back('{1'b1, 2'd0, 16'd2});
      start(4'd3, 16'd2, 32'hFFFFFFC0, 32'h100, 32'h40, 32'h40, 0);
      wait_issue(n);
      pulse_dones(0, 2);
      @(negedge clk);
      chk("no_early_advance", {busy, read_start, frames_done}, {1'b1, 1'b0, 16'd0});
      pulse_dones(3, 0);
      wait_issue(n);
      chk("t3_frames_mid", frames_done, 1);
      pulse_dones(1, 1);
      wait_irq();
      clear_irq();

      // T4: watchdog timeout with read_done withheld
      issue_q.push_back('{32'h2000, 32'h3000, 32'd128});
      fin_q.push_back('{1'b0, 2'd2, 16'd0});
      start(4'd4, 16'd1, 32'h2000, 32'h3000, 0, 0, 24'd20);
      wait_issue(n);
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         cyc();
         write_done = (i == 3);
         @(negedge clk);
         if (status_err == 2'd2) begin n = i; break; end
      end
      write_done = 1'b0;
      chk("timeout_cycle", n, 21);
      chk("timeout_restart", {read_restart, write_restart, busy}, 3'b110);
      wait_irq();
      chk("t4_restarts", {rr_cnt[7:0], wr_cnt[7:0]}, 16'h0101);
      clear_irq();

      // T5: bad log2 (13 and 2), zero frames, largest legal size
      rs0 = rs_cnt;
      fin_q.push_back('{1'b0, 2'd1, 16'd0});
      start(4'd13, 16'd1, 32'h1000, 32'h8000, 0, 0, 0);
      wait_irq();
      clear_irq();
      fin_q.push_back('{1'b0, 2'd1, 16'd0});
      start(4'd2, 16'd1, 32'h1000, 32'h8000, 0, 0, 0);
      wait_irq();
      clear_irq();
      fin_q.push_back('{1'b1, 2'd0, 16'd0});
      start(4'd10, 16'd0, 32'h1000, 32'h8000, 0, 0, 0);
      wait_irq();
      chk("t5_no_issue", rs_cnt - rs0, 0);
      clear_irq();
      issue_q.push_back('{32'h40000, 32'h80000, 32'd32768});
      fin_q.push_back('{1'b1, 2'd0, 16'd1});
      start(4'd12, 16'd1, 32'h40000, 32'h80000, 0, 0, 0);
      wait_issue(n);
      pulse_dones(1, 1);
      wait_irq();
      clear_irq();

      // T6: abort mid-WAIT with a concurrent done and irq_clear; clear during FINISH
      issue_q.push_back('{32'h100, 32'h900, 32'd256});
      issue_q.push_back('{32'h300, 32'hB00, 32'd256});
      fin_q.push_back('{1'b0, 2'd0, 16'd1});
      start(4'd5, 16'd4, 32'h100, 32'h900, 32'h200, 32'h200, 0);
      wait_issue(n);
      pulse_dones(1, 1);
      wait_issue(n);
      cyc();
      cfg_start = 1'b1; cfg_src_addr = 32'hDEAD0000;
      cyc();
      cfg_start = 1'b0;
      cfg_abort = 1'b1; read_done = 1'b1; irq_clear = 1'b1;
      cyc();
      cfg_abort = 1'b0; read_done = 1'b0; irq_clear = 1'b0;
      @(negedge clk);
      chk("abort_state", {status_err, busy, read_restart, write_restart, frames_done},
          {2'd3, 1'b0, 1'b1, 1'b1, 16'd1});
      irq_clear = 1'b1;
      cyc();
      irq_clear = 1'b0;
      wait_irq();
      chk("t6_restarts", {rr_cnt[7:0], wr_cnt[7:0]}, 16'h0202);
      clear_irq();

      // reset mid-job: no restart pulse, everything back to zero
      issue_q.push_back('{32'h500, 32'h600, 32'd64});
      start(4'd3, 16'd2, 32'h500, 32'h600, 0, 0, 0);
      wait_issue(n);
      cyc();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      @(negedge clk);
      chk("midjob_reset", {busy, read_restart, write_restart, frames_done, top_read_addr}, 0);
      repeat (3) cyc();
      chk("final_restarts", {rr_cnt[7:0], wr_cnt[7:0]}, 16'h0202);
      chk("queues_empty", issue_q.size() + fin_q.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: sim time exceeded");
      $fatal(1);
   end

endmodule
